// File: rtl/stepper_multi_seq_pkg.sv
// Shared types, phase table and index helpers for the multi-channel stepper sequencer.
package stepper_pkg;

    typedef enum logic [1:0] {
        WAVE    = 2'd0,
        FULL    = 2'd1,
        HALF    = 2'd2,
        RELEASE = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int unsigned PHASES = 8;

    // Half-step sequence as {ina1, ina2, inb1, inb2}; odd entries energise both coils.
    localparam logic [3:0] PHASE_TABLE [PHASES] = '{
        4'b1000, 4'b1010, 4'b0010, 4'b0110,
        4'b0100, 4'b0101, 4'b0001, 4'b1001
    };

    function automatic logic [3:0] coil_bits(input logic [2:0] idx);
        return PHASE_TABLE[idx];
    endfunction

    // Wave drive lives on even entries, two-phase drive on odd entries.
    function automatic logic [2:0] align_idx(input logic [2:0] idx, input mode_e mode);
        logic [2:0] res;
        case (mode)
            WAVE:    res = idx & 3'b110;
            FULL:    res = idx | 3'b001;
            default: res = idx;
        endcase
        return res;
    endfunction

    function automatic logic [2:0] next_idx(input logic [2:0] idx, input mode_e mode,
                                            input logic dir);
        logic [2:0] delta;
        delta = (mode == HALF) ? 3'd1 : 3'd2;
        return dir ? (idx + delta) : (idx - delta);
    endfunction

endpackage

// File: rtl/stepper_multi_seq_if.sv
// Step-command handshake bundle between the UI logic (master) and the sequencer (slave).
interface stepper_multi_seq_if #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned STEP_W = 16
) ();
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [CH_W-1:0]       cmd_ch;
    logic [STEP_W-1:0]     cmd_steps;
    logic                  cmd_dir;
    stepper_pkg::mode_e    cmd_mode;

    modport master (
        output cmd_valid, cmd_ch, cmd_steps, cmd_dir, cmd_mode,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_ch, cmd_steps, cmd_dir, cmd_mode,
        output cmd_ready
    );
endinterface

// File: rtl/stepper_multi_seq_channel.sv
// One stepper channel: IDLE/RUN/HOLD FSM, tick/step/hold counters and phase index.
// STEPPER_SOFTSTART_EN stretches the first two step periods of each command (4x, 2x).
module stepper_channel
    import stepper_pkg::*;
#(
    parameter int unsigned TICKS_PER_STEP = 13500,
    parameter int unsigned HOLD_CYCLES    = 2700000,
    parameter int unsigned STEP_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_accept,
    input  logic [STEP_W-1:0] i_steps,
    input  logic              i_dir,
    input  mode_e             i_mode,
    input  logic              i_stop,
    output logic [3:0]        o_coil,
    output logic              o_stanby,
    output logic              o_busy,
    output logic              o_done
);
`ifdef STEPPER_SOFTSTART_EN
    localparam int unsigned TICK_MAX = 4 * TICKS_PER_STEP;
`else
    localparam int unsigned TICK_MAX = TICKS_PER_STEP;
`endif
    localparam int unsigned TICK_W = $clog2(TICK_MAX);
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_e            r_state;
    logic [2:0]        r_idx;
    mode_e             r_mode;
    logic              r_dir;
    logic [STEP_W-1:0] r_steps;
    logic [TICK_W-1:0] r_tick;
    logic [HOLD_W-1:0] r_hold;

    logic              w_tick_last;
    logic [2:0]        w_idx_align;
    logic [2:0]        w_idx_step;

    assign w_idx_align = align_idx(r_idx, i_mode);
    assign w_idx_step  = next_idx(r_idx, r_mode, r_dir);

`ifdef STEPPER_SOFTSTART_EN
    logic [1:0] r_step_num;

    // Saturating count of steps taken in the current command selects the period.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_step_num <= 2'd0;
        end else if (i_accept) begin
            r_step_num <= 2'd0;
        end else if (r_state == RUN && !i_stop && w_tick_last && r_step_num != 2'd2) begin
            r_step_num <= r_step_num + 2'd1;
        end
    end

    always_comb begin
        case (r_step_num)
            2'd0:    w_tick_last = (r_tick == TICK_W'(4 * TICKS_PER_STEP - 1));
            2'd1:    w_tick_last = (r_tick == TICK_W'(2 * TICKS_PER_STEP - 1));
            default: w_tick_last = (r_tick == TICK_W'(TICKS_PER_STEP - 1));
        endcase
    end
`else
    assign w_tick_last = (r_tick == TICK_W'(TICKS_PER_STEP - 1));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_idx    <= 3'd0;
            r_mode   <= WAVE;
            r_dir    <= 1'b0;
            r_steps  <= '0;
            r_tick   <= '0;
            r_hold   <= '0;
            o_coil   <= 4'd0;
            o_stanby <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (i_accept) begin
                // Accept only reaches a channel that is not busy (IDLE or HOLD).
                if (i_mode == RELEASE) begin
                    r_state  <= IDLE;
                    o_coil   <= 4'd0;
                    o_stanby <= 1'b0;
                    o_busy   <= 1'b0;
                end else begin
                    r_idx    <= w_idx_align;
                    r_mode   <= i_mode;
                    r_dir    <= i_dir;
                    r_steps  <= i_steps;
                    r_tick   <= '0;
                    r_hold   <= '0;
                    o_coil   <= coil_bits(w_idx_align);
                    o_stanby <= 1'b1;
                    if (i_steps == '0) begin
                        r_state <= HOLD;
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                    end else begin
                        r_state <= RUN;
                        o_busy  <= 1'b1;
                    end
                end
            end else begin
                case (r_state)
                    RUN: begin
                        if (i_stop) begin
                            r_state <= HOLD;
                            r_hold  <= '0;
                            o_busy  <= 1'b0;
                            o_done  <= 1'b1;
                        end else if (w_tick_last) begin
                            r_tick  <= '0;
                            r_idx   <= w_idx_step;
                            o_coil  <= coil_bits(w_idx_step);
                            r_steps <= r_steps - STEP_W'(1);
                            if (r_steps == STEP_W'(1)) begin
                                r_state <= HOLD;
                                r_hold  <= '0;
                                o_busy  <= 1'b0;
                                o_done  <= 1'b1;
                            end
                        end else begin
                            r_tick <= r_tick + TICK_W'(1);
                        end
                    end
                    HOLD: begin
                        if (r_hold == HOLD_W'(HOLD_CYCLES - 1)) begin
                            r_state  <= IDLE;
                            o_coil   <= 4'd0;
                            o_stanby <= 1'b0;
                        end else begin
                            r_hold <= r_hold + HOLD_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/stepper_multi_seq.sv
// Multi-channel stepper sequencer top: command decode, per-channel engines, shared VREF PWM.
// Optional STEPPER_SOFTSTART_EN enables soft-start step periods inside each channel.
module stepper_multi_seq
    import stepper_pkg::*;
#(
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned TICKS_PER_STEP = 13500,
    parameter int unsigned HOLD_CYCLES    = 2700000,
    parameter int unsigned STEP_W         = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    stepper_multi_seq_if.slave    cmd,
    input  logic [NUM_CH-1:0]     stop,
    input  logic [4*NUM_CH-1:0]   vref_level,
    output logic [NUM_CH-1:0]     ina1,
    output logic [NUM_CH-1:0]     ina2,
    output logic [NUM_CH-1:0]     inb1,
    output logic [NUM_CH-1:0]     inb2,
    output logic [NUM_CH-1:0]     stanby,
    output logic [NUM_CH-1:0]     vref_pwm,
    output logic [NUM_CH-1:0]     busy,
    output logic [NUM_CH-1:0]     done
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CH_N = 1 << CH_W;

    logic [3:0]        r_pwm_cnt;
    logic              w_ch_ok;
    logic [CH_N-1:0]   w_busy_pad;
    logic [CH_N-1:0]   w_stop_pad;
    logic [NUM_CH-1:0] w_accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pwm_cnt <= 4'd0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 4'd1;
        end
    end

    // Padded copies keep the channel select in range for non power-of-two NUM_CH.
    assign w_busy_pad    = CH_N'(busy);
    assign w_stop_pad    = CH_N'(stop);
    assign w_ch_ok       = ({1'b0, cmd.cmd_ch} < (CH_W + 1)'(NUM_CH));
    assign cmd.cmd_ready = w_ch_ok && !w_busy_pad[cmd.cmd_ch] && !w_stop_pad[cmd.cmd_ch];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [3:0] w_coil;

        assign w_accept[c] = cmd.cmd_valid && cmd.cmd_ready && (cmd.cmd_ch == CH_W'(c));

        stepper_channel #(
            .TICKS_PER_STEP (TICKS_PER_STEP),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .STEP_W         (STEP_W)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .i_accept (w_accept[c]),
            .i_steps  (cmd.cmd_steps),
            .i_dir    (cmd.cmd_dir),
            .i_mode   (cmd.cmd_mode),
            .i_stop   (stop[c]),
            .o_coil   (w_coil),
            .o_stanby (stanby[c]),
            .o_busy   (busy[c]),
            .o_done   (done[c])
        );

        assign ina1[c]     = w_coil[3];
        assign ina2[c]     = w_coil[2];
        assign inb1[c]     = w_coil[1];
        assign inb2[c]     = w_coil[0];
        assign vref_pwm[c] = (r_pwm_cnt < vref_level[4*c +: 4]) && stanby[c];
    end

endmodule

// File: tb/tb_stepper_multi_seq.sv
// Directed self-checking bench for stepper_multi_seq (2 channels, 4 ticks/step, 10 hold cycles).
module tb_stepper_multi_seq;
    import stepper_pkg::*;

    localparam int unsigned NCH   = 2;
    localparam int unsigned TPS   = 4;
    localparam int unsigned HOLDC = 10;
    localparam int unsigned SW    = 16;

    logic             clk;
    logic             reset;
    logic [NCH-1:0]   stop;
    logic [4*NCH-1:0] vref_level;
    logic [NCH-1:0]   ina1, ina2, inb1, inb2, stanby, vref_pwm, busy, done;
    int               total;
    int               bad;

    stepper_multi_seq_if #(.NUM_CH(NCH), .STEP_W(SW)) cmd_if ();

    stepper_multi_seq #(
        .NUM_CH(NCH), .TICKS_PER_STEP(TPS), .HOLD_CYCLES(HOLDC), .STEP_W(SW)
    ) dut (
        .clk(clk), .reset(reset), .cmd(cmd_if), .stop(stop), .vref_level(vref_level),
        .ina1(ina1), .ina2(ina2), .inb1(inb1), .inb2(inb2), .stanby(stanby),
        .vref_pwm(vref_pwm), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        mode_e      mode;
        logic       dir;
        int         steps;
        logic [3:0] exp_coil;
        int         exp_lat;
    } vec_t;

    function automatic logic [3:0] coil(input int c);
        return {ina1[c], ina2[c], inb1[c], inb2[c]};
    endfunction

    function automatic int per(input int n);
`ifdef STEPPER_SOFTSTART_EN
        return (n == 0) ? 4 * TPS : (n == 1) ? 2 * TPS : TPS;
`else
        return TPS;
`endif
    endfunction

    function automatic int lat(input int steps);
        int s = 1;
        for (int i = 0; i < steps; i++) s += per(i);
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int ch, input mode_e m, input logic d, input int steps,
                         output logic rdy);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_ch    = 1'(ch);
        cmd_if.cmd_steps = 16'(steps);
        cmd_if.cmd_dir   = d;
        cmd_if.cmd_mode  = m;
        #1;
        rdy = cmd_if.cmd_ready;
        tick();
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int ch, input int limit, output int k);
        k = 1;
        while (!done[ch] && k < limit) begin
            tick();
            k++;
        end
    endtask

    initial begin
        vec_t       vt [7];
        int         k, c1, c2, c3, n0, n1;
        logic       rdy;
        logic [3:0] e;

        total = 0;
        bad   = 0;
        vt[0] = '{HALF, 1'b1, 1, 4'b1010, 5};
        vt[1] = '{FULL, 1'b1, 2, 4'b0101, 9};
        vt[2] = '{WAVE, 1'b0, 3, 4'b0001, 13};
        vt[3] = '{HALF, 1'b0, 2, 4'b0100, 9};
        vt[4] = '{FULL, 1'b0, 0, 4'b0101, 1};
        vt[5] = '{WAVE, 1'b1, 4, 4'b0100, 17};
        vt[6] = '{HALF, 1'b1, 9, 4'b0101, 37};

        reset            = 1'b1;
        stop             = '0;
        vref_level       = '0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_ch    = 1'b0;
        cmd_if.cmd_steps = '0;
        cmd_if.cmd_dir   = 1'b0;
        cmd_if.cmd_mode  = WAVE;
        repeat (3) tick();
        reset = 1'b0;

        chk("rst_coil0", coil(0), 0);
        chk("rst_coil1", coil(1), 0);
        chk("rst_stanby", stanby, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", cmd_if.cmd_ready, 1);

        // Half mode, 3 steps forward on ch0, followed through hold into standby
        c1 = 1 + per(0);
        c2 = c1 + per(1);
        c3 = c2 + per(2);
        issue(0, HALF, 1'b1, 3, rdy);
        chk("b_ready", rdy, 1);
        for (k = 1; k <= c3 + HOLDC + 1; k++) begin
            e = (k < c1) ? 4'b1000 : (k < c2) ? 4'b1010 : (k < c3) ? 4'b0010 :
                (k < c3 + HOLDC) ? 4'b0110 : 4'b0000;
            chk($sformatf("b_coil0_k%0d", k), coil(0), e);
            chk($sformatf("b_done0_k%0d", k), done[0], k == c3);
            chk($sformatf("b_busy0_k%0d", k), busy[0], k < c3);
            chk($sformatf("b_stanby0_k%0d", k), stanby[0], k < c3 + HOLDC);
            tick();
        end

        // Table of chained commands on ch1
        for (int i = 0; i < 7; i++) begin
            issue(1, vt[i].mode, vt[i].dir, vt[i].steps, rdy);
            chk($sformatf("t%0d_ready", i), rdy, 1);
            wait_done(1, 200, k);
`ifdef STEPPER_SOFTSTART_EN
            chk($sformatf("t%0d_latency", i), k, lat(vt[i].steps));
`else
            chk($sformatf("t%0d_latency", i), k, vt[i].exp_lat);
`endif
            chk($sformatf("t%0d_coil1", i), coil(1), vt[i].exp_coil);
            chk($sformatf("t%0d_busy1", i), busy[1], 0);
            chk($sformatf("t%0d_stanby1", i), stanby[1], 1);
            chk($sformatf("t%0d_coil0_idle", i), coil(0), 0);
            tick();
            tick();
        end

        // Wave reverse from idx 3 on ch0 while ch1 runs a full step
        issue(0, WAVE, 1'b0, 2, rdy);
        chk("d_ready0", rdy, 1);
        chk("d_align", coil(0), 4'b0010);
        chk("d_busy0", busy[0], 1);
        issue(1, FULL, 1'b1, 1, rdy);
        chk("d_ready1_ch0_run", rdy, 1);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_ch    = 1'b0;
        cmd_if.cmd_mode  = HALF;
        cmd_if.cmd_steps = 16'd1;
        #1;
        chk("d_refuse0", cmd_if.cmd_ready, 0);
        tick();
        cmd_if.cmd_valid = 1'b0;
        k = 3;
        c2 = c1 + per(1);
        while (k < c2) begin
            if (k == c2 - 1) chk("d_refuse0_late", cmd_if.cmd_ready, 0);
            tick();
            k++;
            if (k == c1) chk("d_step1", coil(0), 4'b1000);
            if (k == c1 + 1) begin
                chk("d_ch1_coil", coil(1), 4'b1001);
                chk("d_ch1_done", done[1], 1);
                chk("d_ch0_unaffected", coil(0), 4'b1000);
            end
        end
        chk("d_wrap_coil", coil(0), 4'b0001);
        chk("d_done0", done[0], 1);
        chk("d_ready0_after", cmd_if.cmd_ready, 1);

        // Stop mid-run, then stop racing a command in HOLD
        issue(0, HALF, 1'b1, 5, rdy);
        chk("e_ready", rdy, 1);
        k = 1;
        while (k < c1) begin
            tick();
            k++;
        end
        chk("e_step1", coil(0), 4'b1001);
        chk("e_busy", busy[0], 1);
        tick();
        stop[0] = 1'b1;
        tick();
        stop[0] = 1'b0;
        chk("e_stop_done", done[0], 1);
        chk("e_stop_busy", busy[0], 0);
        chk("e_stop_stanby", stanby[0], 1);
        chk("e_stop_coil", coil(0), 4'b1001);
        tick();
        chk("e_done_once", done[0], 0);
        stop[0]          = 1'b1;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_ch    = 1'b0;
        cmd_if.cmd_mode  = HALF;
        cmd_if.cmd_steps = 16'd1;
        #1;
        chk("e_stop_wins_ready", cmd_if.cmd_ready, 0);
        tick();
        stop[0]          = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        chk("e_no_accept_busy", busy[0], 0);
        repeat (TPS + 1) tick();
        chk("e_no_step_coil", coil(0), 4'b1001);
        chk("e_hold_stanby", stanby[0], 1);
        chk("e_no_done", done[0], 0);

        // Zero-step command, then release from HOLD
        issue(0, HALF, 1'b1, 0, rdy);
        chk("f_ready", rdy, 1);
        chk("f_done", done[0], 1);
        chk("f_coil", coil(0), 4'b1001);
        chk("f_busy", busy[0], 0);
        chk("f_stanby", stanby[0], 1);
        tick();
        chk("f_done_once", done[0], 0);
        issue(0, RELEASE, 1'b0, 0, rdy);
        chk("g_ready", rdy, 1);
        chk("g_coil", coil(0), 0);
        chk("g_stanby", stanby[0], 0);
        chk("g_done", done[0], 0);
        chk("g_busy", busy[0], 0);
        tick();
        chk("g_done_later", done[0], 0);

        // VREF PWM: zero in IDLE, level/16 duty while energised
        vref_level = {4'd15, 4'd4};
        chk("h_ch1_idle", stanby[1], 0);
        n0 = 0;
        n1 = 0;
        repeat (16) begin
            n0 += int'(vref_pwm[0]);
            n1 += int'(vref_pwm[1]);
            tick();
        end
        chk("h_idle_pwm0", n0, 0);
        chk("h_idle_pwm1", n1, 0);
        issue(0, HALF, 1'b1, 8, rdy);
        chk("h_ready0", rdy, 1);
        issue(1, HALF, 1'b1, 8, rdy);
        chk("h_ready1", rdy, 1);
        n0 = 0;
        n1 = 0;
        repeat (16) begin
            n0 += int'(vref_pwm[0]);
            n1 += int'(vref_pwm[1]);
            tick();
        end
        chk("h_duty_lvl4", n0, 4);
        chk("h_duty_lvl15", n1, 15);

        // Reset while both channels run
        chk("i_busy_before", busy, 2'b11);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("i_coil0", coil(0), 0);
        chk("i_coil1", coil(1), 0);
        chk("i_stanby", stanby, 0);
        chk("i_busy", busy, 0);
        chk("i_done", done, 0);
        chk("i_vref", vref_pwm, 0);
        n0 = 0;
        repeat (2 * TPS + 2) begin
            tick();
            n0 += int'(done[0]) + int'(done[1]) + int'(busy[0]) + int'(busy[1]);
        end
        chk("i_quiet_after_reset", n0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
